// File: rtl/timer_pkg.sv
// Shared definitions for the buzzer countdown timer: controller states and
// clock/tone defaults used to size the dividers.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAUSE = 2'd1,
        RUN   = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam int CLK_HZ  = 50_000_000;
    localparam int TONE_HZ = 2000;

    // Buzzer half-period in clock cycles for a square wave at tone_hz.
    function automatic int half_period(input int clk_hz, input int tone_hz);
        return clk_hz / (2 * tone_hz);
    endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Free-running modulo-N counter with hold (en low), synchronous clear, and a
// combinational wrap strobe asserted in the enabled cycle that returns to 0.
module mod_n_counter #(
    parameter int N = 2
) (
    input  logic clk_50MHz,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;

    assign wrap = en && (cnt == LAST);

    // clr beats en so a clear on the same cycle as a wrap still lands on 0.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/buzzer_timer_ctrl.sv
// Seconds countdown timer driven by debounced command pulses; sounds a
// square-wave buzzer for ALARM_SECS seconds when the count reaches zero.
//
//   state | meaning
//   IDLE  | no count loaded, waiting for a nonzero load
//   PAUSE | count loaded, divider frozen, waiting for start
//   RUN   | counting down one second per tick divider wrap
//   ALARM | count hit zero, buzzer toggling for ALARM_SECS ticks
module buzzer_timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV   = CLK_HZ,
    parameter int TONE_HALF  = half_period(CLK_HZ, TONE_HZ),
    parameter int ALARM_SECS = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    input  logic             cmd_load,
    input  logic             cmd_reset,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] secs_left,
    output logic             running,
    output logic             alarm,
    output logic             tick_1hz,
    output logic             buzzer
);

    localparam int AW = $clog2(ALARM_SECS + 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] secs_nx;
    logic [AW-1:0]    alarm_cnt;
    logic [AW-1:0]    alarm_cnt_nx;
    logic             tick_nx;
    logic             buzzer_nx;

    logic             tick_en;
    logic             tick_clr;
    logic             tick_wrap;
    logic             tone_en;
    logic             tone_clr;
    logic             tone_wrap;

    // Any higher-priority command pending this cycle freezes both dividers.
    assign tick_en = !cmd_reset && !cmd_stop && ((state == RUN) || (state == ALARM));
    assign tone_en = !cmd_reset && !cmd_stop && (state == ALARM);

    mod_n_counter #(.N(TICK_DIV)) u_tick_div (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .en        (tick_en),
        .clr       (tick_clr),
        .wrap      (tick_wrap)
    );

    mod_n_counter #(.N(TONE_HALF)) u_tone_div (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .en        (tone_en),
        .clr       (tone_clr),
        .wrap      (tone_wrap)
    );

    always_comb begin
        state_nx     = state;
        secs_nx      = secs_left;
        alarm_cnt_nx = alarm_cnt;
        tick_clr     = 1'b0;
        tone_clr     = 1'b0;
        tick_nx      = 1'b0;
        buzzer_nx    = 1'b0;

        if (cmd_reset) begin
            state_nx     = IDLE;
            secs_nx      = '0;
            alarm_cnt_nx = '0;
            tick_clr     = 1'b1;
            tone_clr     = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!cmd_stop && !cmd_start && cmd_load && (load_value != '0)) begin
                        state_nx = PAUSE;
                        secs_nx  = load_value;
                        tick_clr = 1'b1;
                    end
                end
                PAUSE: begin
                    if (cmd_stop) begin
                        state_nx = PAUSE;
                    end else if (cmd_start) begin
                        state_nx = RUN;
                    end else if (cmd_load) begin
                        secs_nx  = load_value;
                        tick_clr = 1'b1;
                        if (load_value == '0) begin
                            state_nx = IDLE;
                        end
                    end
                end
                RUN: begin
                    if (cmd_stop) begin
                        state_nx = PAUSE;
                    end else if (tick_wrap) begin
                        tick_nx = 1'b1;
                        secs_nx = secs_left - CNT_W'(1);
                        if (secs_left == CNT_W'(1)) begin
                            state_nx     = ALARM;
                            alarm_cnt_nx = AW'(ALARM_SECS);
                            tick_clr     = 1'b1;
                            tone_clr     = 1'b1;
                        end
                    end
                end
                ALARM: begin
                    if (cmd_stop) begin
                        state_nx     = IDLE;
                        alarm_cnt_nx = '0;
                    end else begin
                        buzzer_nx = tone_wrap ? !buzzer : buzzer;
                        if (tick_wrap) begin
                            tick_nx      = 1'b1;
                            alarm_cnt_nx = alarm_cnt - AW'(1);
                            if (alarm_cnt == AW'(1)) begin
                                state_nx  = IDLE;
                                buzzer_nx = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            secs_left <= '0;
            alarm_cnt <= '0;
            running   <= 1'b0;
            alarm     <= 1'b0;
            tick_1hz  <= 1'b0;
            buzzer    <= 1'b0;
        end else begin
            state     <= state_nx;
            secs_left <= secs_nx;
            alarm_cnt <= alarm_cnt_nx;
            running   <= (state_nx == RUN);
            alarm     <= (state_nx == ALARM);
            tick_1hz  <= tick_nx;
            buzzer    <= buzzer_nx;
        end
    end

endmodule

// File: tb/tb_buzzer_timer_ctrl.sv
// Directed and randomized checks of buzzer_timer_ctrl against a cycle-count
// reference model of the countdown/alarm behaviour.
module tb_buzzer_timer_ctrl;

    localparam int TICK_DIV   = 10;
    localparam int TONE_HALF  = 2;
    localparam int ALARM_SECS = 2;
    localparam int CNT_W      = 8;

    logic             clk_50MHz = 1'b0;
    logic             reset     = 1'b1;
    logic             cmd_start = 1'b0;
    logic             cmd_stop  = 1'b0;
    logic             cmd_load  = 1'b0;
    logic             cmd_reset = 1'b0;
    logic [CNT_W-1:0] load_value = '0;
    logic [CNT_W-1:0] secs_left;
    logic             running;
    logic             alarm;
    logic             tick_1hz;
    logic             buzzer;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode name, seconds left, cycles into the current
    // second while running, and cycles elapsed since alarm entry.
    string m_mode;
    int    m_secs;
    int    m_frac;
    int    m_elapsed;
    bit    m_tick;

    buzzer_timer_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .TONE_HALF  (TONE_HALF),
        .ALARM_SECS (ALARM_SECS),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_50MHz  (clk_50MHz),
        .reset      (reset),
        .cmd_start  (cmd_start),
        .cmd_stop   (cmd_stop),
        .cmd_load   (cmd_load),
        .cmd_reset  (cmd_reset),
        .load_value (load_value),
        .secs_left  (secs_left),
        .running    (running),
        .alarm      (alarm),
        .tick_1hz   (tick_1hz),
        .buzzer     (buzzer)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode    = "IDLE";
        m_secs    = 0;
        m_frac    = 0;
        m_elapsed = 0;
        m_tick    = 1'b0;
    endtask

    task automatic model_step();
        m_tick = 1'b0;
        if (cmd_reset) begin
            model_reset();
        end else if (m_mode == "IDLE") begin
            if (!cmd_stop && !cmd_start && cmd_load && load_value != 0) begin
                m_secs = int'(load_value);
                m_frac = 0;
                m_mode = "PAUSE";
            end
        end else if (m_mode == "PAUSE") begin
            if (cmd_stop) begin
                m_mode = "PAUSE";
            end else if (cmd_start) begin
                m_mode = "RUN";
            end else if (cmd_load) begin
                m_secs = int'(load_value);
                m_frac = 0;
                if (load_value == 0) m_mode = "IDLE";
            end
        end else if (m_mode == "RUN") begin
            if (cmd_stop) begin
                m_mode = "PAUSE";
            end else begin
                m_frac++;
                if (m_frac == TICK_DIV) begin
                    m_frac = 0;
                    m_tick = 1'b1;
                    m_secs--;
                    if (m_secs == 0) begin
                        m_mode    = "ALARM";
                        m_elapsed = 0;
                    end
                end
            end
        end else begin
            if (cmd_stop) begin
                m_mode = "IDLE";
            end else begin
                m_elapsed++;
                if (m_elapsed % TICK_DIV == 0) m_tick = 1'b1;
                if (m_elapsed == ALARM_SECS * TICK_DIV) begin
                    m_mode = "IDLE";
                    m_frac = 0;
                end
            end
        end
    endtask

    function automatic bit exp_buzz();
        if (m_mode != "ALARM") return 1'b0;
        return bit'((m_elapsed / TONE_HALF) % 2);
    endfunction

    // One clock: advance the model with the driven commands, then compare
    // every output one time unit after the edge and drop the pulses.
    task automatic cyc();
        model_step();
        @(posedge clk_50MHz);
        #1;
        chk("secs_left", 32'(secs_left), 32'(m_secs));
        chk("running",   32'(running),   32'(m_mode == "RUN"));
        chk("alarm",     32'(alarm),     32'(m_mode == "ALARM"));
        chk("tick_1hz",  32'(tick_1hz),  32'(m_tick));
        chk("buzzer",    32'(buzzer),    32'(exp_buzz()));
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        cmd_load  = 1'b0;
        cmd_reset = 1'b0;
    endtask

    task automatic do_load(input int v);
        cmd_load   = 1'b1;
        load_value = CNT_W'(v);
        cyc();
    endtask

    task automatic do_start();
        cmd_start = 1'b1;
        cyc();
    endtask

    task automatic do_stop();
        cmd_stop = 1'b1;
        cyc();
    endtask

    initial begin
        int r;
        model_reset();

        // Reset values
        repeat (2) @(posedge clk_50MHz);
        #1;
        chk("rst_secs",    32'(secs_left), 32'd0);
        chk("rst_running", 32'(running),   32'd0);
        chk("rst_alarm",   32'(alarm),     32'd0);
        chk("rst_tick",    32'(tick_1hz),  32'd0);
        chk("rst_buzzer",  32'(buzzer),    32'd0);
        reset = 1'b0;
        cyc();

        // Load 3, start, countdown into alarm
        do_load(3);
        chk("t1_loaded", 32'(secs_left), 32'd3);
        do_start();
        chk("t1_running", 32'(running), 32'd1);
        for (int k = 1; k <= 30; k++) begin
            cyc();
            if (k == 9)  chk("t1_pre10",  32'(secs_left), 32'd3);
            if (k == 10) chk("t1_sec2",   32'(secs_left), 32'd2);
            if (k == 10) chk("t1_tick10", 32'(tick_1hz),  32'd1);
            if (k == 20) chk("t1_sec1",   32'(secs_left), 32'd1);
            if (k == 30) chk("t1_sec0",   32'(secs_left), 32'd0);
            if (k == 30) chk("t1_alarm",  32'(alarm),     32'd1);
        end

        // Alarm tone and timeout
        for (int j = 1; j <= 20; j++) begin
            cyc();
            if (j == 1)  chk("t2_buz1",   32'(buzzer), 32'd0);
            if (j == 2)  chk("t2_buz2",   32'(buzzer), 32'd1);
            if (j == 4)  chk("t2_buz4",   32'(buzzer), 32'd0);
            if (j == 19) chk("t2_alarm19", 32'(alarm), 32'd1);
            if (j == 20) chk("t2_alarm20", 32'(alarm), 32'd0);
            if (j == 20) chk("t2_buz20",  32'(buzzer), 32'd0);
        end

        // Pause keeps the fractional second
        do_load(5);
        do_start();
        repeat (4) cyc();
        do_stop();
        chk("t3_paused", 32'(running), 32'd0);
        repeat (50) cyc();
        chk("t3_hold", 32'(secs_left), 32'd5);
        do_start();
        for (int j = 1; j <= 6; j++) begin
            cyc();
            if (j == 5) chk("t3_res5", 32'(secs_left), 32'd5);
            if (j == 6) chk("t3_res6", 32'(secs_left), 32'd4);
        end

        // Same-cycle command priority
        do_stop();
        cmd_stop  = 1'b1;
        cmd_start = 1'b1;
        cyc();
        chk("t4_stop_wins", 32'(running), 32'd0);
        cmd_reset  = 1'b1;
        cmd_load   = 1'b1;
        load_value = 8'd7;
        cyc();
        chk("t4_reset_wins", 32'(secs_left), 32'd0);

        // Zero load and load while running
        do_load(0);
        do_start();
        chk("t5_zero_start", 32'(running), 32'd0);
        do_load(4);
        do_start();
        repeat (3) cyc();
        do_load(9);
        chk("t5_run_load", 32'(secs_left), 32'd4);
        chk("t5_run_still", 32'(running), 32'd1);

        // Randomized single-command traffic
        cmd_reset = 1'b1;
        cyc();
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                cmd_reset = 1'b1;
            end else if (r < 8) begin
                cmd_stop = 1'b1;
            end else if (r < 16) begin
                cmd_start = 1'b1;
            end else if (r < 24) begin
                cmd_load   = 1'b1;
                load_value = CNT_W'($urandom_range(0, 3));
            end
            cyc();
        end

        // Async reset mid-alarm, off the clock edge
        cmd_reset = 1'b1;
        cyc();
        do_load(1);
        do_start();
        for (int i = 0; i < 20 && m_mode != "ALARM"; i++) cyc();
        chk("t6_in_alarm", 32'(alarm), 32'd1);
        repeat (2) cyc();
        chk("t6_buz_pre", 32'(buzzer), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_async_buz",   32'(buzzer),    32'd0);
        chk("t6_async_alarm", 32'(alarm),     32'd0);
        chk("t6_async_secs",  32'(secs_left), 32'd0);
        @(posedge clk_50MHz);
        #1;
        reset = 1'b0;
        model_reset();
        cyc();

        // Stop silences the alarm
        do_load(1);
        do_start();
        for (int i = 0; i < 20 && m_mode != "ALARM"; i++) cyc();
        repeat (3) cyc();
        do_stop();
        chk("t6_stop_alarm", 32'(alarm),  32'd0);
        chk("t6_stop_buz",   32'(buzzer), 32'd0);
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
